// File: rtl/gen_fifo_burst_ctrl.sv
// Burst controller: runs the pattern generator into the FIFO write port for one
// burst of latched length, with stall on FIFO full, abort, and a done pulse.
module gen_fifo_burst_ctrl #(
  parameter int unsigned BURST_W   = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned PAT_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               fifo_full_i,
  output logic               clrh_addr_o,
  output logic               enh_gen_o,
  output logic               fifo_wr_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [BURST_W-1:0] words_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [BURST_W-1:0] len_q;
  logic               wr;
  logic               last_word;
  logic               addr_wrap;

  // Write strobe is combinational so a word lands in the same cycle the FIFO frees up.
  assign wr          = (state == RUN) && !fifo_full_i && !abort_i;
  assign fifo_wr_o   = wr;
  assign enh_gen_o   = wr;
  assign last_word   = (words_o == (len_q - 1'b1));
  assign addr_wrap   = (addr_o == ADDR_W'(PAT_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      addr_o      <= '0;
      words_o     <= '0;
      clrh_addr_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clrh_addr_o <= 1'b1;
          done_o      <= 1'b0;
          if (start_i) begin
            len_q   <= burst_len_i;
            words_o <= '0;
            addr_o  <= '0;
            busy_o  <= 1'b1;
            state   <= LOAD;
          end else begin
            busy_o  <= 1'b0;
          end
        end
        LOAD: begin
          clrh_addr_o <= 1'b0;
          if (abort_i || (len_q == '0)) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (abort_i) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end else if (wr) begin
            words_o <= words_o + 1'b1;
            addr_o  <= addr_wrap ? '0 : addr_o + 1'b1;
            if (last_word) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          clrh_addr_o <= 1'b1;
          busy_o      <= 1'b0;
          done_o      <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          clrh_addr_o <= 1'b1;
          busy_o      <= 1'b0;
          done_o      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
